// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and DataMem.
// slave: arbiter view (requests and memory responses in); master: environment view.
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [2:0]  d_func;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [2:0]  mem_func;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_func, d_wdata,
    input  mem_rdata, mem_ready,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_read, mem_write,
    output mem_addr, mem_func, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_func, d_wdata,
    output mem_rdata, mem_ready,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_read, mem_write,
    input  mem_addr, mem_func, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Request/grant scheduler sharing one memory port between fetch and load/store.
// Ports: clk, rst (async active-low), bus (slave), busy;
// MEM_ARB_PERF_EN adds perf_conflict/perf_wait saturating counters.
module unified_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_arbiter_if.slave bus,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]          perf_conflict,
  output logic [31:0]          perf_wait,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        func_q, func_d;
  logic              we_q, we_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              if_win, d_win;
  logic              starve_max;

  assign starve_max = (starve_q == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      func_q      <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      func_q      <= func_d;
      we_q        <= we_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    func_d      = func_q;
    we_d        = we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_win      = 1'b0;
    d_win       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Data wins ties unless fetch has been passed over too often.
        d_win  = bus.d_req && !(bus.if_req && starve_max);
        if_win = bus.if_req && !d_win;
        unique case (1'b1)
          d_win: begin
            state_d = BUSY_D;
            addr_d  = bus.d_addr;
            func_d  = bus.d_func;
            wdata_d = bus.d_wdata;
            we_d    = bus.d_we;
          end
          if_win: begin
            state_d = BUSY_I;
            addr_d  = bus.if_addr;
            func_d  = 3'b010;
            we_d    = 1'b0;
          end
          default: ;
        endcase
      end
      BUSY_I: begin
        if (bus.mem_ready) begin
          state_d     = IDLE;
          if_rdata_d  = bus.mem_rdata;
          if_rvalid_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d    = IDLE;
          d_rvalid_d = 1'b1;
          if (!we_q) d_rdata_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_win) starve_d = '0;
    else if (d_win && !starve_max) starve_d = starve_q + 1'b1;
  end

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  // Decoded straight from state so reset drops the command at once.
  assign bus.mem_en    = (state_q != IDLE);
  assign bus.mem_read  = (state_q == BUSY_I) ||
                         ((state_q == BUSY_D) && !we_q);
  assign bus.mem_write = (state_q == BUSY_D) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_func  = func_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != IDLE);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_q, wait_q;
  logic        any_req, any_gnt;

  assign any_req = bus.if_req || bus.d_req;
  assign any_gnt = if_win || d_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
      wait_q     <= '0;
    end else begin
      if ((state_q == IDLE) && bus.if_req && bus.d_req && !(&conflict_q))
        conflict_q <= conflict_q + 32'd1;
      if (any_req && !any_gnt && !(&wait_q))
        wait_q <= wait_q + 32'd1;
    end
  end

  assign perf_conflict = conflict_q;
  assign perf_wait     = wait_q;
`endif

endmodule
